riscv_multicycle_ctrl_fsm: RTL

//  Multicycle RISC-V control unit: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction.

---
 rtl/riscv_multicycle_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_ctrl_fsm.sv
// Multicycle RISC-V control unit.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives the
// datapath mux selects and the cache req/ready handshake, and waits out cache
// misses. An illegal opcode or a memory timeout sends it into an absorbing
// ERROR state that only rst_n can leave. The state_o debug encoding follows the
// state list order, starting from FETCH = 0 and ending at ERROR = 13.
module riscv_multicycle_ctrl_fsm #(
  parameter bit EXT_OPS     = 1'b1,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       error,
  output logic [1:0] err_code,
  output logic [3:0] state_o
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_ERROR  = 4'd13
  } state_t;

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   ir_wr, reg_wr, pc_update, branch;
  logic                   mem_wait;
  logic                   timeout_hit;
  logic [31:0]            cnt_ext;

  // A wait state is one that holds mem_req and stalls on mem_ready.
  assign mem_wait    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign cnt_ext     = 32'(cnt_q);
  // This wait cycle would be the MEM_TIMEOUT-th one without mem_ready.
  assign timeout_hit = (MEM_TIMEOUT != 0) && ((cnt_ext + 32'd1) >= 32'(MEM_TIMEOUT));

  assign error    = |err_code_q;
  assign err_code = err_code_q;
  assign state_o  = state_q;

  // State, wait counter and sticky error code; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // Next state, wait counter update and Moore outputs (pc_write is the Mealy term).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    result_src = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_wr     = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_SW:            imm_src = 3'b001;
          OP_BEQ:           imm_src = 3'b010;
          OP_JAL:           imm_src = 3'b011;
          OP_LUI, OP_AUIPC: imm_src = 3'b100;
          default:          imm_src = 3'b000;
        endcase
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_JALR: begin
            if (EXT_OPS) begin
              state_d = S_JALR;
            end else begin
              state_d    = S_ERROR;
              err_code_d = 2'b01;
            end
          end
          OP_LUI, OP_AUIPC: begin
            if (EXT_OPS) begin
              state_d = S_LUI;
            end else begin
              state_d    = S_ERROR;
              err_code_d = 2'b01;
            end
          end
          default: begin
            state_d    = S_ERROR;
            err_code_d = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_SW) ? 3'b001 : 3'b000;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d    = S_ERROR;
          err_code_d = 2'b01;
        end
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr     = 1'b1;
        result_src = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr     = 1'b1;
        result_src = 2'b00;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target already in ALUOut; the ALU forms oldPC+4 for rd.
        pc_update  = 1'b1;
        result_src = 2'b00;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        pc_update  = 1'b1;
        result_src = 2'b10;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        // alu_src_a 11 selects a zero operand so lui yields the bare U-immediate.
        imm_src   = 3'b100;
        alu_src_b = 2'b01;
        alu_src_a = (op == OP_AUIPC) ? 2'b01 : 2'b11;
        state_d   = S_ALUWB;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    if (mem_wait && !mem_ready) begin
      if (cnt_q != '1) cnt_d = cnt_q + TIMEOUT_W'(1);
      if (timeout_hit) begin
        state_d    = S_ERROR;
        err_code_d = 2'b10;
      end
    end

    if (state_d != state_q) cnt_d = '0;

    if (stall) begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_code_d = err_code_q;
    end

    ir_write  = ir_wr & ~stall;
    reg_write = reg_wr & ~stall;
    pc_write  = (pc_update | (branch & zero)) & ~stall;

    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      imm_src    = 3'b000;
      result_src = 2'b00;
    end
  end

endmodule
